// File: rtl/rx_feed_arbiter.sv
// rtl/rx_feed_arbiter.sv - round-robin packet arbiter feeding the 18-byte market-data receiver
// Grants one feed per packet; a stalled packet is padded out so the receiver's byte counter stays aligned.
module rx_feed_arbiter #(
    parameter int         N_FEEDS     = 4,
    parameter int         PKT_LEN     = 18,
    parameter int         TIMEOUT_CYC = 64,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_FEEDS*8-1:0]         feed_byte,
    input  logic [N_FEEDS-1:0]           feed_valid,
    output logic [N_FEEDS-1:0]           feed_ready,
    output logic [7:0]                   rx_byte,
    output logic                         rx_valid,
    output logic [$clog2(N_FEEDS)-1:0]   grant_id,
    output logic                         busy,
    output logic                         abort_pulse,
    output logic [$clog2(N_FEEDS)-1:0]   abort_id
);
    localparam int              GW          = $clog2(N_FEEDS);
    localparam int              SW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [4:0]      LAST_BYTE   = 5'(PKT_LEN - 1);
    localparam logic [SW-1:0]   STALL_LIMIT = SW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;

    state_t         state, state_next;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  winner;
    logic [GW-1:0]  scan_idx;
    logic           any_req;
    logic [4:0]     byte_cnt;
    logic [SW-1:0]  stall_cnt;
    logic           xfer;
    logic           timeout;
    logic [7:0]     grant_byte;

    // Search upward from the feed after the last winner; first requester wins.
    always_comb begin
        any_req  = 1'b0;
        winner   = last_grant;
        scan_idx = last_grant;
        for (int i = 1; i <= N_FEEDS; i++) begin
            scan_idx = GW'((int'(last_grant) + i) % N_FEEDS);
            if (!any_req && feed_valid[scan_idx]) begin
                any_req = 1'b1;
                winner  = scan_idx;
            end
        end
    end

    assign grant_byte = feed_byte[8*int'(grant_id) +: 8];
    assign xfer       = (state == STREAM) && feed_valid[grant_id];
    assign timeout    = (state == STREAM) && !feed_valid[grant_id] && (stall_cnt == STALL_LIMIT);

    always_comb begin
        feed_ready = '0;
        if (state == STREAM) begin
            feed_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) state_next = STREAM;
            end
            STREAM: begin
                if (xfer && byte_cnt == LAST_BYTE) begin
                    state_next = IDLE;
                end else if (timeout) begin
                    // Nothing reached the receiver yet, so the grant can be dropped without padding.
                    state_next = (byte_cnt == 5'd0) ? IDLE : PAD;
                end
            end
            PAD: begin
                if (byte_cnt == LAST_BYTE) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            abort_pulse <= 1'b0;
            abort_id    <= '0;
            last_grant  <= GW'(N_FEEDS - 1);
            byte_cnt    <= 5'd0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_next;
            busy        <= (state_next != IDLE);
            abort_pulse <= 1'b0;
            rx_valid    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id   <= winner;
                        last_grant <= winner;
                        byte_cnt   <= 5'd0;
                        stall_cnt  <= '0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        rx_byte   <= grant_byte;
                        rx_valid  <= 1'b1;
                        byte_cnt  <= byte_cnt + 5'd1;
                        stall_cnt <= '0;
                    end else if (timeout) begin
                        if (byte_cnt != 5'd0) begin
                            abort_pulse <= 1'b1;
                            abort_id    <= grant_id;
                        end
                    end else begin
                        stall_cnt <= stall_cnt + SW'(1);
                    end
                end
                PAD: begin
                    rx_byte  <= PAD_BYTE;
                    rx_valid <= 1'b1;
                    byte_cnt <= byte_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
